// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - write port and dual read port bundle for register_file
interface register_file_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [WIDTH-1:0]  rdata_a;
  logic              rvalid_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_b;
  logic              rvalid_b;

  modport master (
    output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    input  rdata_a, rvalid_a, rdata_b, rvalid_b
  );

  modport slave (
    input  we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    output rdata_a, rvalid_a, rdata_b, rvalid_b
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 1W/2R register file with registered reads and write-first bypass
module register_file #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 1
) (
  input logic               clk,
  input logic               rst_n,
  register_file_if.slave    bus
);
  localparam int NREGS = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [NREGS];
  logic             write_ok;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;

  // Same-cycle write to the read address is forwarded; r0 (when hardwired) wins over the bypass.
  always_comb begin
    write_ok = bus.we && !((ZERO_R0 != 0) && (bus.waddr == '0));
    next_a   = mem[bus.raddr_a];
    next_b   = mem[bus.raddr_b];
    if (write_ok && (bus.waddr == bus.raddr_a)) next_a = bus.wdata;
    if (write_ok && (bus.waddr == bus.raddr_b)) next_b = bus.wdata;
    if ((ZERO_R0 != 0) && (bus.raddr_a == '0)) next_a = '0;
    if ((ZERO_R0 != 0) && (bus.raddr_b == '0)) next_b = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (write_ok) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rdata_a  <= '0;
      bus.rvalid_a <= 1'b0;
      bus.rdata_b  <= '0;
      bus.rvalid_b <= 1'b0;
    end else begin
      bus.rvalid_a <= bus.re_a;
      bus.rvalid_b <= bus.re_b;
      if (bus.re_a) bus.rdata_a <= next_a;
      if (bus.re_b) bus.rdata_b <= next_b;
    end
  end
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file
module tb_register_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [8];
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  logic [7:0] hold_a;
  logic [7:0] e;

  register_file_if #(.WIDTH(8), .ADDR_W(3)) bus ();

  register_file #(.WIDTH(8), .ADDR_W(3), .ZERO_R0(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_read(input logic w, input logic [2:0] wa,
                                            input logic [7:0] wd, input logic [2:0] ra);
    if (ra == 3'd0) return 8'h00;
    if (w && wa != 3'd0 && wa == ra) return wd;
    return ref_mem[ra];
  endfunction

  // Drives one cycle, pushes expected read data, updates the model, samples 1ns after the edge.
  task automatic drive(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                       input logic ea, input logic [2:0] ra, input logic eb, input logic [2:0] rb);
    bus.we = w; bus.waddr = wa; bus.wdata = wd;
    bus.re_a = ea; bus.raddr_a = ra; bus.re_b = eb; bus.raddr_b = rb;
    if (ea) q_a.push_back(model_read(w, wa, wd, ra));
    if (eb) q_b.push_back(model_read(w, wa, wd, rb));
    if (w && wa != 3'd0) ref_mem[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  task automatic test_reset();
    drive(1'b1, 3'd3, 8'hAA, 1'b1, 3'd3, 1'b0, 3'd0);
    e = q_a.pop_front();
    checks++;
    if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== e) begin
      errors++;
      $display("FAIL pre_reset_read: got %b/%h expected 1/%h", bus.rvalid_a, bus.rdata_a, e);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rvalid_a, bus.rvalid_b, bus.rdata_a, bus.rdata_b} !== 18'd0) begin
      errors++;
      $display("FAIL async_reset: got va=%b vb=%b a=%h b=%h expected all 0",
               bus.rvalid_a, bus.rvalid_b, bus.rdata_a, bus.rdata_b);
    end
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    q_a.delete(); q_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd3);
    e = q_a.pop_front();
    checks++;
    if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== e || e !== 8'h00) begin
      errors++;
      $display("FAIL reset_r3_a: got %b/%h expected 1/00", bus.rvalid_a, bus.rdata_a);
    end
    e = q_b.pop_front();
    checks++;
    if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== e) begin
      errors++;
      $display("FAIL reset_r3_b: got %b/%h expected 1/%h", bus.rvalid_b, bus.rdata_b, e);
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 3'd1, 8'hAA, 1'b0, 3'd0, 1'b0, 3'd0);
    drive(1'b1, 3'd2, 8'h55, 1'b0, 3'd0, 1'b0, 3'd0);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd2);
    e = q_a.pop_front();
    checks++;
    if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== e || e !== 8'hAA) begin
      errors++;
      $display("FAIL read_a_r1: got %b/%h expected 1/aa", bus.rvalid_a, bus.rdata_a);
    end
    e = q_b.pop_front();
    checks++;
    if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== e || e !== 8'h55) begin
      errors++;
      $display("FAIL read_b_r2: got %b/%h expected 1/55", bus.rvalid_b, bus.rdata_b);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 3'd4, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0);
    drive(1'b1, 3'd4, 8'h22, 1'b1, 3'd4, 1'b1, 3'd4);
    e = q_a.pop_front();
    void'(q_b.pop_front());
    checks++;
    if (bus.rdata_a !== e || e !== 8'h22) begin
      errors++;
      $display("FAIL bypass_a: got %h expected 22", bus.rdata_a);
    end
    checks++;
    if (bus.rdata_b !== 8'h22) begin
      errors++;
      $display("FAIL bypass_b: got %h expected 22", bus.rdata_b);
    end
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 1'b0, 3'd0);
    e = q_a.pop_front();
    checks++;
    if (bus.rdata_a !== e) begin
      errors++;
      $display("FAIL bypass_after: got %h expected %h", bus.rdata_a, e);
    end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 1'b1, 3'd0);
    for (int k = 0; k < 2; k++) begin
      e = q_a.pop_front();
      checks++;
      if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== e || e !== 8'h00) begin
        errors++;
        $display("FAIL zero_a_%0d: got %b/%h expected 1/00", k, bus.rvalid_a, bus.rdata_a);
      end
      e = q_b.pop_front();
      checks++;
      if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== e) begin
        errors++;
        $display("FAIL zero_b_%0d: got %b/%h expected 1/%h", k, bus.rvalid_b, bus.rdata_b, e);
      end
      if (k == 0) drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0);
    end
  endtask

  task automatic test_hold_valid();
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 3'd0);
    hold_a = q_a.pop_front();
    checks++;
    if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== hold_a) begin
      errors++;
      $display("FAIL hold_first: got %b/%h expected 1/%h", bus.rvalid_a, bus.rdata_a, hold_a);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 3'(k + 1));
      e = q_b.pop_front();
      checks++;
      if (bus.rvalid_a !== 1'b0 || bus.rdata_a !== hold_a) begin
        errors++;
        $display("FAIL hold_idle_%0d: got %b/%h expected 0/%h", k, bus.rvalid_a, bus.rdata_a, hold_a);
      end
      checks++;
      if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== e) begin
        errors++;
        $display("FAIL hold_port_b_%0d: got %b/%h expected 1/%h", k, bus.rvalid_b, bus.rdata_b, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 8'(i * 8'h11), 1'b0, 3'd0, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b0, 3'd0);
      e = q_a.pop_front();
      checks++;
      if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== e || e !== 8'(i * 8'h11)) begin
        errors++;
        $display("FAIL b2b_r%0d: got %b/%h expected 1/%h", i, bus.rvalid_a, bus.rdata_a, 8'(i * 8'h11));
      end
    end
    idle();
    checks++;
    if (bus.rvalid_a !== 1'b0 || bus.rvalid_b !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got %b/%b expected 0/0", bus.rvalid_a, bus.rvalid_b);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re_a = 1'b0; bus.raddr_a = '0; bus.re_b = 1'b0; bus.raddr_b = '0;
    #1;
    checks++;
    if ({bus.rvalid_a, bus.rvalid_b, bus.rdata_a, bus.rdata_b} !== 18'd0) begin
      errors++;
      $display("FAIL reset_state: got va=%b vb=%b a=%h b=%h expected all 0",
               bus.rvalid_a, bus.rvalid_b, bus.rdata_a, bus.rdata_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_hold_valid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
